// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the scoreboard hazard unit
//
// Purpose: id_kind encodings, pending-counter width and the issue-latency helper.
// Ports: none (package).
package hazard_pkg;

    localparam int SB_CW = 3;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_MULDIV = 2'd2,
        KIND_OTHER  = 2'd3
    } kind_e;

    // Value loaded into a pending counter on issue: issue latency minus one.
    // ALU and "other" results forward next cycle, so they leave the counter at 0.
    function automatic logic [SB_CW-1:0] issue_cnt(input kind_e kind,
                                                  input int    load_lat,
                                                  input int    md_lat);
        logic [SB_CW-1:0] v;
        case (kind)
            KIND_LOAD:   v = SB_CW'(load_lat - 1);
            KIND_MULDIV: v = SB_CW'(md_lat - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one per-register pending-result counter
//
// Purpose: holds cycles remaining until a register's in-flight result is
//          forwardable; load wins over the free-running decrement.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : load i_load_val this edge
//   i_load_val    : value to load (issue latency minus one)
//   o_cnt         : current count, 0 means the register is ready
module sb_counter
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [SB_CW-1:0] i_load_val,
    output logic [SB_CW-1:0] o_cnt
);

    logic [SB_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - register scoreboard with stall/flush/issue control
//
// Purpose: tracks pending results per architectural register, detects data,
//          branch-in-ID and mul/div structural hazards for the instruction in
//          ID, and produces stall / flush / issue plus a stall-cycle counter.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_valid                        : valid instruction in IF/ID
//   id_rs1, id_rs2, id_use_rs1/2    : source registers and read enables
//   id_rd, id_reg_write             : destination and write enable
//   id_kind                         : 0 ALU, 1 LOAD, 2 MULDIV, 3 other
//   id_is_branch                    : conditional branch in ID
//   ex_redirect                     : taken branch/jump resolved this cycle
//   stall                           : hold PC/IF-ID, bubble into ID/EX
//   flush_if_id, flush_id_ex        : squash the respective pipeline registers
//   issue                           : ID instruction advances this cycle
//   stall_count                     : saturating count of stall cycles
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int RW       = 5,
    parameter int LOAD_LAT = 2,
    parameter int MD_LAT   = 4,
    parameter int BR_IN_ID = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic [1:0]    id_kind,
    input  logic          id_is_branch,
    input  logic          ex_redirect,
    output logic          stall,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          issue,
    output logic [31:0]   stall_count
);

    kind_e            w_kind;
    logic [SB_CW-1:0] w_cnt [NREG];
    logic [SB_CW-1:0] w_load_val;
    logic             w_rs1_pending;
    logic             w_rs2_pending;
    logic             w_br_hazard;
    logic             w_data_hazard;
    logic             w_struct_hazard;
    logic             w_stall;
    logic             w_issue;
    logic             w_wr_en;

    logic [SB_CW-1:0] r_md_busy;
    logic [RW-1:0]    r_ex_rd;
    logic             r_ex_wr;
    logic [31:0]      r_stall_count;

    assign w_kind     = kind_e'(id_kind);
    assign w_load_val = issue_cnt(w_kind, LOAD_LAT, MD_LAT);

    // Scoreboard update only for an instruction that actually issues; a
    // squashed or stalled instruction leaves the counters to decrement.
    assign w_wr_en = w_issue && id_reg_write;

    // x0 is hardwired zero and never becomes pending.
    assign w_cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_wr_en && (id_rd == RW'(r))),
            .i_load_val (w_load_val),
            .o_cnt      (w_cnt[r])
        );
    end

    // Hazard checks read the counters before this instruction's own update,
    // so an instruction that reads and writes the same register sees the
    // older producer.
    assign w_rs1_pending = id_use_rs1 && (id_rs1 != '0) && (w_cnt[id_rs1] != '0);
    assign w_rs2_pending = id_use_rs2 && (id_rs2 != '0) && (w_cnt[id_rs2] != '0);

    // Branches compare in ID, so even a single-cycle ALU result still in EX
    // is too late to forward into the comparator.
    assign w_br_hazard = (BR_IN_ID != 0) && id_is_branch && r_ex_wr && (r_ex_rd != '0)
                      && ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                          (id_use_rs2 && (id_rs2 == r_ex_rd)));

    assign w_data_hazard   = w_rs1_pending || w_rs2_pending || w_br_hazard;
    assign w_struct_hazard = (w_kind == KIND_MULDIV) && (r_md_busy != '0);

    // Reset gates every control output so nothing advances while held.
    assign w_stall = rst_n && id_valid && !ex_redirect && (w_data_hazard || w_struct_hazard);
    assign w_issue = rst_n && id_valid && !w_stall && !ex_redirect;

    assign stall       = w_stall;
    assign issue       = w_issue;
    assign flush_if_id = rst_n && ex_redirect;
    assign flush_id_ex = rst_n && ex_redirect;
    assign stall_count = r_stall_count;

    // Non-pipelined mul/div unit occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_busy <= '0;
        end else if (w_issue && (w_kind == KIND_MULDIV)) begin
            r_md_busy <= SB_CW'(MD_LAT - 1);
        end else if (r_md_busy != '0) begin
            r_md_busy <= r_md_busy - 1'b1;
        end
    end

    // Destination of the instruction now in EX; ex_wr drops on any bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rd <= '0;
            r_ex_wr <= 1'b0;
        end else begin
            if (w_issue) begin
                r_ex_rd <= id_rd;
            end
            r_ex_wr <= w_issue && id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - self-checking bench for scoreboard_hazard_unit
module tb_scoreboard_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [1:0]  id_kind;
    logic        id_is_branch;
    logic        ex_redirect;

    logic        stall, flush_if_id, flush_id_ex, issue;
    logic [31:0] stall_count;
    logic        nb_stall, nb_flush_if_id, nb_flush_id_ex, nb_issue;
    logic [31:0] nb_stall_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] kind;
        logic       br;
    } instr_t;

    typedef struct {
        string tag;
        logic  stall;
        logic  issue;
        logic  flush;
    } exp_t;

    exp_t exp_q[$];

    scoreboard_hazard_unit #(
        .NREG(32), .RW(5), .LOAD_LAT(2), .MD_LAT(4), .BR_IN_ID(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_kind(id_kind),
        .id_is_branch(id_is_branch), .ex_redirect(ex_redirect),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .issue(issue), .stall_count(stall_count)
    );

    scoreboard_hazard_unit #(
        .NREG(32), .RW(5), .LOAD_LAT(2), .MD_LAT(4), .BR_IN_ID(0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_kind(id_kind),
        .id_is_branch(id_is_branch), .ex_redirect(ex_redirect),
        .stall(nb_stall), .flush_if_id(nb_flush_if_id), .flush_id_ex(nb_flush_id_ex),
        .issue(nb_issue), .stall_count(nb_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic instr_t mk(input int kind, input int rd, input bit wr,
                                  input int rs1, input bit u1,
                                  input int rs2, input bit u2, input bit br);
        instr_t i;
        i.valid = 1'b1;
        i.kind  = 2'(kind);
        i.rd    = 5'(rd);
        i.wr    = wr;
        i.rs1   = 5'(rs1);
        i.u1    = u1;
        i.rs2   = 5'(rs2);
        i.u2    = u2;
        i.br    = br;
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit redir);
        id_valid     = i.valid;
        id_rs1       = i.rs1;
        id_rs2       = i.rs2;
        id_use_rs1   = i.u1;
        id_use_rs2   = i.u2;
        id_rd        = i.rd;
        id_reg_write = i.wr;
        id_kind      = i.kind;
        id_is_branch = i.br;
        ex_redirect  = redir;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_kind = 2'd0; id_is_branch = 1'b0; ex_redirect = 1'b0;
    endtask

    // Drive one ID-stage cycle, queue the expected response, then compare.
    task automatic step(input string tag, input instr_t i, input bit redir,
                        input bit e_stall, input bit e_issue);
        exp_t e;
        @(negedge clk);
        drive(i, redir);
        exp_q.push_back('{tag: tag, stall: e_stall, issue: e_issue, flush: redir});
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
        check({e.tag, ".issue"}, 32'(issue), 32'(e.issue));
        check({e.tag, ".flush_if_id"}, 32'(flush_if_id), 32'(e.flush));
        check({e.tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e.flush));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam int K_ALU = 0, K_LOAD = 1, K_MD = 2, K_OTH = 3;

    initial begin
        idle();
        rst_n = 1'b1;

        // Reset state: outputs forced low even with valid + redirect asserted
        @(negedge clk);
        rst_n = 1'b0;
        id_valid = 1'b1;
        ex_redirect = 1'b1;
        #1;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.issue", 32'(issue), 32'd0);
        check("rst.flush_if_id", 32'(flush_if_id), 32'd0);
        check("rst.flush_id_ex", 32'(flush_id_ex), 32'd0);
        check("rst.stall_count", stall_count, 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Load-use: one stall cycle
        step("lu.load", mk(K_LOAD, 5, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        step("lu.add0", mk(K_ALU, 6, 1, 5, 1, 0, 0, 0), 0, 1, 0);
        step("lu.add1", mk(K_ALU, 6, 1, 5, 1, 0, 0, 0), 0, 0, 1);
        check("lu.stall_count", stall_count, 32'd1);

        // ALU back-to-back: no stall
        step("alu.add", mk(K_ALU, 3, 1, 1, 1, 2, 1, 0), 0, 0, 1);
        step("alu.sub", mk(K_ALU, 9, 1, 3, 1, 3, 1, 0), 0, 0, 1);
        check("alu.stall_count", stall_count, 32'd1);

        // Structural mul/div: DIV waits 3 cycles
        step("md.mul", mk(K_MD, 7, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        for (int c = 0; c < 3; c++)
            step($sformatf("md.div_wait%0d", c), mk(K_MD, 8, 1, 0, 0, 0, 0, 0), 0, 1, 0);
        step("md.div", mk(K_MD, 8, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        check("md.stall_count", stall_count, 32'd4);

        // Read-and-write the same register sees the older producer
        step("self.load1", mk(K_LOAD, 11, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        step("self.load2w", mk(K_LOAD, 11, 1, 11, 1, 0, 0, 0), 0, 1, 0);
        step("self.load2", mk(K_LOAD, 11, 1, 11, 1, 0, 0, 0), 0, 0, 1);
        step("self.addw", mk(K_ALU, 12, 1, 11, 1, 0, 0, 0), 0, 1, 0);
        step("self.add", mk(K_ALU, 12, 1, 11, 1, 0, 0, 0), 0, 0, 1);
        check("self.stall_count", stall_count, 32'd6);

        // Branch in ID: BR_IN_ID=1 stalls once, BR_IN_ID=0 does not
        do_reset();
        step("br.add", mk(K_ALU, 4, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        check("br.nb_add_issue", 32'(nb_issue), 32'd1);
        step("br.beq0", mk(K_OTH, 0, 0, 4, 1, 1, 1, 1), 0, 1, 0);
        check("br.nb_beq_stall", 32'(nb_stall), 32'd0);
        check("br.nb_beq_issue", 32'(nb_issue), 32'd1);
        step("br.beq1", mk(K_OTH, 0, 0, 4, 1, 1, 1, 1), 0, 0, 1);
        check("br.stall_count", stall_count, 32'd1);
        check("br.nb_stall_count", nb_stall_count, 32'd0);

        // Redirect over a load-use hazard: squashed LOAD must not mark x10
        do_reset();
        step("rd.load", mk(K_LOAD, 5, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        step("rd.squash", mk(K_LOAD, 10, 1, 5, 1, 0, 0, 0), 1, 0, 0);
        step("rd.reader", mk(K_ALU, 12, 1, 10, 1, 5, 1, 0), 0, 0, 1);
        check("rd.stall_count", stall_count, 32'd0);

        // Reset two cycles into a MUL dependency stall, then x0 handling
        do_reset();
        step("rs.mul", mk(K_MD, 7, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        step("rs.dep0", mk(K_ALU, 9, 1, 7, 1, 0, 0, 0), 0, 1, 0);
        step("rs.dep1", mk(K_ALU, 9, 1, 7, 1, 0, 0, 0), 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs.mid_stall", 32'(stall), 32'd0);
        check("rs.mid_issue", 32'(issue), 32'd0);
        check("rs.mid_stall_count", stall_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rs.dep_after", mk(K_ALU, 9, 1, 7, 1, 0, 0, 0), 0, 0, 1);
        step("x0.load", mk(K_LOAD, 0, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        step("x0.reader", mk(K_ALU, 13, 1, 0, 1, 0, 1, 0), 0, 0, 1);
        step("x0.branch", mk(K_OTH, 0, 0, 0, 1, 0, 1, 1), 0, 0, 1);
        check("x0.stall_count", stall_count, 32'd0);

        @(negedge clk);
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- NREG, 32: architectural registers; x0 is never tracked.
- RW, 5: register-index width, equal to clog2(NREG).
- LOAD_LAT, 2: cycles from load issue to a forwardable result (range 1..7).
- MD_LAT, 4: cycles from mul/div issue to a forwardable result (range 1..7); the mul/div unit is not pipelined.
- BR_IN_ID, 1: when 1, branches resolve in ID and also need EX-stage ALU results.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- id_valid, in, 1: a valid instruction is in IF/ID.
- id_rs1, id_rs2, in, RW each: ID source registers.
- id_use_rs1, id_use_rs2, in, 1 each: the matching source is actually read.
- id_rd, in, RW: ID destination register.
- id_reg_write, in, 1: the ID instruction writes id_rd.
- id_kind, in, 2: 0 ALU, 1 LOAD, 2 MULDIV, 3 other.
- id_is_branch, in, 1: the ID instruction is a conditional branch.
- ex_redirect, in, 1: taken branch or jump resolved this cycle.
- stall, out, 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- flush_if_id, out, 1: squash IF/ID.
- flush_id_ex, out, 1: squash ID/EX.
- issue, out, 1: the ID instruction advances this cycle.
- stall_count, out, 32: saturating count of stall cycles.

Function
REQ-003 Each register r from 1 to NREG-1 SHALL hold a 3-bit pending counter cnt[r]; cnt[0] SHALL read as 0 at all times.
REQ-004 Every clock edge, each nonzero cnt[r] SHALL decrement by 1.
REQ-005 The signal issue SHALL equal id_valid AND NOT stall AND NOT ex_redirect.
REQ-006 When issue is 1, id_reg_write is 1 and id_rd is not 0, cnt[id_rd] SHALL load the issue latency minus 1, where the issue latency is 1 for ALU and other, LOAD_LAT for LOAD, and MD_LAT for MULDIV; this load SHALL override that register's decrement in the same cycle.
REQ-007 A data hazard SHALL exist when a used source rs is not 0 and cnt[rs] is not 0.
REQ-008 When BR_IN_ID is 1, a data hazard SHALL also exist when id_is_branch is 1, a used source equals ex_rd, ex_wr is 1 and ex_rd is not 0.
- ex_rd and ex_wr are registers holding the id_rd and id_reg_write of the previous issued instruction.
- When the previous cycle did not issue, ex_wr SHALL be 0.
REQ-009 md_busy SHALL be a counter loaded with MD_LAT-1 on a MULDIV issue and decremented while nonzero.
REQ-010 A structural hazard SHALL exist when id_kind is MULDIV and md_busy is not 0.
REQ-011 The output stall SHALL be 1 when id_valid is 1, ex_redirect is 0, and a data or structural hazard exists.
REQ-012 ex_redirect SHALL take priority over stall:
- flush_if_id and flush_id_ex SHALL be 1 in that cycle.
- stall SHALL be 0 in that cycle.
- The scoreboard SHALL NOT be updated by the squashed ID instruction.
- Counter decrements SHALL continue.
REQ-013 stall_count SHALL increment on every cycle in which stall is 1, and SHALL saturate at 0xFFFFFFFF.
REQ-014 stall, flush_if_id, flush_id_ex and issue SHALL be combinational from the inputs and the current state, with zero-cycle latency.
REQ-015 When an instruction writes a register that it also reads, the hazard check SHALL use cnt before that instruction's own update.

Reset
REQ-016 While rst_n is 0, the following SHALL be 0, asynchronously and regardless of clk: all cnt, md_busy, ex_rd, ex_wr and stall_count.
REQ-017 With reset asserted, stall, flush_if_id, flush_id_ex and issue SHALL all read 0.
REQ-018 A reset asserted mid-stall SHALL clear all pending state, so the first cycle after release issues any valid instruction without a hazard.

Structure
REQ-019 The package hazard_pkg SHALL hold:
- the id_kind encodings KIND_ALU, KIND_LOAD, KIND_MULDIV and KIND_OTHER;
- the counter width constant SB_CW = 3.
REQ-020 One sub-module, sb_counter, SHALL implement a single pending counter, with load and decrement, and be instantiated NREG-1 times.

Verification
REQ-021 Load-use case:
- Stimulus: LOAD writing x5 issues, then an ADD reading x5 follows, with LOAD_LAT=2.
- Required: stall is 1 for exactly 1 cycle, then the ADD issues, and stall_count is 1.
REQ-022 ALU back-to-back case:
- Stimulus: ADD writing x3, then SUB reading x3.
- Required: stall stays 0 and both instructions issue on consecutive cycles.
REQ-023 Structural mul/div case:
- Stimulus: MUL writing x7, then an independent DIV writing x8, with MD_LAT=4.
- Required: the DIV stalls 3 cycles, then issues.
REQ-024 Branch-in-ID case:
- Stimulus: BR_IN_ID=1, ADD writing x4, then BEQ reading x4.
- Required: 1 stall cycle.
- Repeat with BR_IN_ID=0: 0 stall cycles.
REQ-025 Redirect during a hazard:
- Stimulus: ex_redirect=1 while a load-use hazard is present.
- Required: stall is 0, both flush outputs are 1, issue is 0, and cnt[id_rd] is unchanged.
REQ-026 Reset mid-operation and x0:
- Stimulus: assert rst_n=0 two cycles into a MUL dependency stall.
- Required: after release, a dependent instruction issues immediately, and a LOAD writing x0 followed by a reader of x0 never stalls.
